// File: rtl/uart_tx_fifo_reader.sv
// Pops one byte from the TX FIFO when idle and serialises it as start + DBIT data (LSB first) + stop.
// tx changes one clock after the pop; the FIFO is only popped in IDLE, and tx_en gates new frames only.
module uart_tx_fifo_reader #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 54
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tx_en,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_rd_data,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [15:0]     baud_q, baud_d;
    logic [5:0]      tick_q, tick_d;
    logic [2:0]      bit_q, bit_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            s_tick, pop, last_stop;

    assign s_tick    = (state_q != IDLE) && (baud_q == 16'(DVSR - 1));
    assign pop       = (state_q == IDLE) && tx_en && !fifo_empty;
    assign last_stop = s_tick && (tick_q == 6'(SB_TICK - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d follows the state being entered so the line is registered with no extra lag
    always_comb begin
        state_d = state_q;
        baud_d  = (state_q == IDLE || s_tick) ? 16'd0 : baud_q + 16'd1;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    shift_d = fifo_rd_data;
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_q == 6'd15) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = DATA;
                        tx_d    = shift_q[0];
                    end else begin
                        tick_d = tick_q + 6'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_q == 6'd15) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'(DBIT - 1)) begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end else begin
                            tx_d = shift_d[0];
                        end
                    end else begin
                        tick_d = tick_q + 6'd1;
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (s_tick) begin
                    if (last_stop) begin
                        tick_d  = '0;
                        state_d = IDLE;
                    end else begin
                        tick_d = tick_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_rd      = rst_n && pop;
        tx_busy      = (state_q != IDLE);
        tx_done_tick = (state_q == STOP) && last_stop;
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Bench: queued bytes feed two instances (8N1 at DVSR=4, 7-bit/2-stop at DVSR=1); line waveform checked against frame arithmetic.
module tb_uart_tx_fifo_reader;

    logic       clk;
    logic       rst_n;
    logic       tx_en1, tx_en2;
    logic       empty1, empty2;
    logic [7:0] data1;
    logic [6:0] data2;
    logic       rd1, tx1, busy1, done1;
    logic       rd2, tx2, busy2, done2;

    logic [7:0] mem [0:63];
    logic [5:0] wr_ptr, rd_ptr;
    int         rd1_cnt, rd2_cnt, cyc;
    int         checks, errors;

    uart_tx_fifo_reader #(.DBIT(8), .SB_TICK(16), .DVSR(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en1), .fifo_empty(empty1),
        .fifo_rd_data(data1), .fifo_rd(rd1), .tx(tx1), .tx_busy(busy1),
        .tx_done_tick(done1)
    );

    uart_tx_fifo_reader #(.DBIT(7), .SB_TICK(32), .DVSR(1)) u_dut_p (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en2), .fifo_empty(empty2),
        .fifo_rd_data(data2), .fifo_rd(rd2), .tx(tx2), .tx_busy(busy2),
        .tx_done_tick(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign empty1 = (rd_ptr == wr_ptr);
    assign data1  = mem[rd_ptr];

    initial begin
        rd_ptr  = '0;
        rd1_cnt = 0;
        rd2_cnt = 0;
        cyc     = 0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd1 === 1'b1) begin
            rd1_cnt <= rd1_cnt + 1;
            rd_ptr  <= rd_ptr + 6'd1;
        end
        if (rd2 === 1'b1) rd2_cnt <= rd2_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr      = wr_ptr + 6'd1;
    endtask

    task automatic wait_rd(input bit which, input int budget, output bit ok, output int at);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            #1;
            if ((which ? rd2 : rd1) === 1'b1) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Called at the cycle where the pop strobe is high; walks the whole frame clock by clock.
    task automatic frame(input bit which, input logic [7:0] b, input int dbit, input int sb,
                         input int dvsr, input int drop_k, input string tag);
        int         bitp, len, idx, bad_wave, bad_busy, done_cnt, done_k;
        logic       exp_tx, o_tx, o_busy, o_done;
        logic [7:0] dec, mask;
        bitp     = 16 * dvsr;
        len      = (16 * (1 + dbit) + sb) * dvsr;
        bad_wave = 0;
        bad_busy = 0;
        done_cnt = 0;
        done_k   = -1;
        dec      = '0;
        mask     = 8'((1 << dbit) - 1);
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (k == drop_k) tx_en1 = 1'b0;
            if (which && k == 1) empty2 = 1'b1;
            o_tx   = which ? tx2 : tx1;
            o_busy = which ? busy2 : busy1;
            o_done = which ? done2 : done1;
            idx    = (k - 1) / bitp;
            if (idx == 0)         exp_tx = 1'b0;
            else if (idx <= dbit) exp_tx = b[idx-1];
            else                  exp_tx = 1'b1;
            if (o_tx !== exp_tx) bad_wave++;
            if (o_busy !== 1'b1) bad_busy++;
            if (o_done === 1'b1) begin
                done_cnt++;
                done_k = k;
            end
            if (idx >= 1 && idx <= dbit && ((k - 1) % bitp) == bitp / 2) dec[idx-1] = o_tx;
        end
        chk({tag, "_wave_errs"}, 32'(bad_wave), 32'd0);
        chk({tag, "_busy_errs"}, 32'(bad_busy), 32'd0);
        chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        chk({tag, "_done_clock"}, 32'(done_k), 32'(len));
        chk({tag, "_decoded"}, 32'(dec), 32'(b & mask));
    endtask

    bit ok;
    int c0, c1, c2, base, bad;

    initial begin
        checks = 0;
        errors = 0;
        wr_ptr = '0;
        rst_n  = 1'b0;
        tx_en1 = 1'b1;
        tx_en2 = 1'b0;
        empty2 = 1'b1;
        data2  = 7'h55;
        push(8'hA5);

        repeat (3) @(negedge clk);
        chk("reset_fifo_rd", 32'(rd1), 32'd0);
        chk("reset_tx", 32'(tx1), 32'd1);
        chk("reset_busy", 32'(busy1), 32'd0);
        chk("reset_done", 32'(done1), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("release_fifo_rd", 32'(rd1), 32'd1);

        frame(1'b0, 8'hA5, 8, 16, 4, 0, "single");
        repeat (20) @(negedge clk);
        chk("single_pop_count", 32'(rd1_cnt), 32'd1);
        chk("single_idle_tx", 32'(tx1), 32'd1);

        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        base = rd1_cnt;
        wait_rd(1'b0, 50, ok, c0);
        chk("b2b_first_rd", 32'(ok), 32'd1);
        frame(1'b0, 8'h00, 8, 16, 4, 0, "b2b0");
        wait_rd(1'b0, 5, ok, c1);
        frame(1'b0, 8'hFF, 8, 16, 4, 0, "b2b1");
        wait_rd(1'b0, 5, ok, c2);
        frame(1'b0, 8'h3C, 8, 16, 4, 0, "b2b2");
        chk("b2b_gap01", 32'(c1 - c0), 32'd641);
        chk("b2b_gap12", 32'(c2 - c1), 32'd641);
        repeat (30) @(negedge clk);
        chk("b2b_pop_count", 32'(rd1_cnt - base), 32'd3);

        push(8'h5A);
        push(8'hC3);
        base = rd1_cnt;
        wait_rd(1'b0, 50, ok, c0);
        chk("gate_first_rd", 32'(ok), 32'd1);
        frame(1'b0, 8'h5A, 8, 16, 4, 100, "gate");
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || busy1 !== 1'b0 || rd1 !== 1'b0) bad++;
        end
        chk("gate_idle_errs", 32'(bad), 32'd0);
        chk("gate_pop_count", 32'(rd1_cnt - base), 32'd1);
        tx_en1 = 1'b1;
        #1;
        chk("gate_reenable_rd", 32'(rd1), 32'd1);
        wait_rd(1'b0, 5, ok, c0);
        frame(1'b0, 8'hC3, 8, 16, 4, 0, "gate2");

        push(8'h96);
        push(8'h2B);
        base = rd1_cnt;
        wait_rd(1'b0, 50, ok, c0);
        chk("rst_first_rd", 32'(ok), 32'd1);
        repeat (280) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx1), 32'd1);
        chk("midrst_busy", 32'(busy1), 32'd0);
        chk("midrst_fifo_rd", 32'(rd1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_rd(1'b0, 10, ok, c0);
        chk("midrst_next_rd", 32'(ok), 32'd1);
        frame(1'b0, 8'h2B, 8, 16, 4, 0, "after_rst");
        repeat (10) @(negedge clk);
        chk("midrst_pop_count", 32'(rd1_cnt - base), 32'd2);

        tx_en2 = 1'b1;
        empty2 = 1'b0;
        wait_rd(1'b1, 20, ok, c0);
        chk("param_first_rd", 32'(ok), 32'd1);
        frame(1'b1, 8'h55, 7, 32, 1, 0, "param");
        repeat (5) @(negedge clk);
        chk("param_pop_count", 32'(rd2_cnt), 32'd1);
        chk("param_idle_tx", 32'(tx2), 32'd1);
        chk("param_idle_busy", 32'(busy2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_reader.md
# uart_tx_fifo_reader

Reader end of the byte FIFO: drains queued bytes and serialises each one onto a UART transmit line. Whenever the FIFO is non-empty and the block is idle, it pops the head byte with a single-cycle read strobe. It then sends one start bit, DBIT data bits LSB first, and the stop bits. It contains its own 16x-oversampling baud tick generator and sits between the TX FIFO and the board's serial pin.

## Interface
- DBIT, 8, data bits per frame (5..8)
- SB_TICK, 16, stop-bit length in oversampling ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2)
- DVSR, 54, clocks per oversampling tick (1..65535); bit time = 16*DVSR clocks
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- tx_en  input  1  when high, new frames may start; sampled only in IDLE
- fifo_empty  input  1  FIFO empty flag
- fifo_rd_data  input  DBIT  FIFO head byte, valid combinationally whenever fifo_empty=0
- fifo_rd  output  1  one-cycle FIFO pop strobe
- tx  output  1  serial line, idle high
- tx_busy  output  1  high in every state except IDLE
- tx_done_tick  output  1  one-cycle pulse on the final clock of a frame's stop period

## Operation
- Reset (rst_n low, asynchronous): state=IDLE, tx=1, tx_busy=0, tx_done_tick=0, tick counter=0, bit/tick counters=0, shift register=0.
- fifo_rd is forced to 0 while rst_n is low.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - fifo_rd = tx_en & ~fifo_empty (combinational).
  - On the edge where fifo_rd=1, latch fifo_rd_data into the shift register, clear the baud counter and tick counter, and go to START.
  - Otherwise stay in IDLE with tx=1.
- Baud generator:
  - 16-bit counter, cleared on leaving IDLE.
  - s_tick is high for one clock when counter==DVSR-1, and the counter wraps to 0 on that clock.
  - Runs only outside IDLE.
- START: tx=0 for 16 ticks, then go to DATA with bit counter=0.
- DATA:
  - tx = shift register bit 0.
  - After 16 ticks, shift right by one and increment the bit counter.
  - After bit DBIT-1, go to STOP.
- STOP:
  - tx=1 for SB_TICK ticks.
  - On the clock where the last tick completes, tx_done_tick=1 and the next state is IDLE.
- tx is registered, so it changes on the clock edge at which the state or bit changes.
- tx_en is ignored outside IDLE. A frame in progress always completes.
- The FIFO is never popped while fifo_empty=1 or outside IDLE. The block pops at most one byte per frame.
- Reset mid-frame: tx goes to 1 immediately, and the frame is abandoned. The popped byte is lost and is not re-read.

## Timing
- Cycle T: IDLE, fifo_rd=1, and the byte is latched.
- T+1: tx falls to 0 (start bit).
- Start bit occupies clocks T+1..T+16*DVSR.
- Data bit i occupies the next 16*DVSR clocks, for each i=0..DBIT-1.
- Stop bits last SB_TICK*DVSR clocks.
- tx_done_tick coincides with the last stop clock, at T+(16*(1+DBIT)+SB_TICK)*DVSR.
- The following clock is IDLE, with tx=1.
- If the FIFO is still non-empty and tx_en=1, fifo_rd asserts in that IDLE clock.
- Back-to-back frame period is therefore (16*(1+DBIT)+SB_TICK)*DVSR + 1 clocks, with a 1-clock extra high gap between frames.
- DVSR=1 gives an s_tick on every clock, and all durations above still hold.

## Test plan
- **Reset:** hold rst_n=0 with fifo_empty=0.
  - Required: fifo_rd=0, tx=1, tx_busy=0.
  - Release reset. Required: fifo_rd=1 in the first clock.
- **Single byte:** DVSR=4, DBIT=8, SB_TICK=16, byte 0xA5.
  - Required: tx low for 64 clocks, then bits 1,0,1,0,0,1,0,1 at 64 clocks each, then high for 64 clocks.
  - Required: tx_done_tick exactly 640 clocks after fifo_rd.
  - Required: exactly one fifo_rd pulse.
- **Back-to-back:** FIFO holds 0x00, 0xFF, 0x3C.
  - Required: three fifo_rd pulses spaced 641 clocks apart.
  - Required: decoded frames match the bytes, with no extra pops after fifo_empty rises.
- **tx_en gating:** drop tx_en mid-frame.
  - Required: the frame completes, no further fifo_rd, tx stays 1.
  - Raise tx_en again. Required: fifo_rd the next clock.
- **Reset mid-frame:** assert rst_n=0 during data bit 3.
  - Required: tx=1 and tx_busy=0 immediately.
  - After release: the next byte from the FIFO is sent, and the interrupted byte is not repeated.
- **Parameters:** DBIT=7, SB_TICK=32, DVSR=1, byte 0x55.
  - Required: start bit 16 clocks, 7 data bits 1,0,1,0,1,0,1 at 16 clocks each, stop high for 32 clocks.
  - Required: frame length 160 clocks.
